image_rom_mux: RTL and testbench

Parametrised, multi-channel successor to the single-port image ROM. It holds one palettised image/sprite store, initialised from a MIF, and shares its single synchronous read port among `NUM_CH` requesters with round-robin arbitration. Each requester uses a req/ack handshake, and read data returns on a fixed two-cycle pipeline. It sits between the ROM contents and the pixel consumers: the VGA drawing path, the sprite engines, and the palette lookup.

---
 rtl/image_rom_mux.sv | 143 ++++++++++++++
 tb/tb_image_rom_mux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/image_rom_mux.sv
// image_rom_mux
// -----------------------------------------------------------------------------
// Palettised image/sprite ROM whose single synchronous read port is shared by
// NUM_CH requesters through a round-robin arbiter. Each requester uses a level
// req / combinational ack handshake. The read data comes back on a fixed
// two-cycle pipeline over a shared rdata bus, and a one-hot rvalid marks its
// owner.
//
// Ports:
//   clock    in   1              rising-edge clock
//   reset_n  in   1              asynchronous active-low reset
//   req      in   NUM_CH         per-channel read request (level)
//   addr     in   NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ack      out  NUM_CH         one-hot grant, same cycle as the accepted req
//   rdata    out  DATA_W         registered read data, holds while rvalid == 0
//   rvalid   out  NUM_CH         one-hot owner of rdata, 2 cycles after ack
//   oob_err  out  1              returned word came from an address >= DEPTH
//
// Build option:
//   IMAGE_ROM_BOUNDS_CHECK_EN - when defined, addresses >= DEPTH never index
//   the ROM. They return OOB_VALUE and raise oob_err. When undefined, the
//   compare is absent and oob_err is tied low.
// -----------------------------------------------------------------------------
module image_rom_mux #(
  parameter int                DATA_W    = 4,
  parameter int                DEPTH     = 201240,
  parameter int                ADDR_W    = $clog2(DEPTH),
  parameter int                NUM_CH    = 2,
  parameter logic [DATA_W-1:0] OOB_VALUE = '0,
  parameter                    INIT_FILE = "image.mif"
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  output logic [NUM_CH-1:0]        ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH-1:0]        rvalid,
  output logic                     oob_err
);

  // A single channel still gets a 1-bit pointer. It simply stays at zero.
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // ROM contents come from the MIF at configuration time. The array is never written.
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0] addr_ch [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_ch[gi] = addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [NUM_CH-1:0] grant;
  logic [PTR_W-1:0]  grant_ch;
  logic              grant_any;
  logic [ADDR_W-1:0] grant_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              grant_oob;

  // Round-robin search that starts at ptr_reg. The first requester found wins.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_c;
    idx       = 0;
    idx_c     = '0;
    grant     = '0;
    grant_ch  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx   = (int'(ptr_reg) + k) % NUM_CH;
      idx_c = PTR_W'(idx);
      if (!grant_any && req[idx_c]) begin
        grant_any = 1'b1;
        grant_ch  = idx_c;
      end
    end
    grant[grant_ch] = grant_any;
    ptr_next = grant_any ? PTR_W'((int'(grant_ch) + 1) % NUM_CH) : ptr_reg;
  end

  // Hold ack low while in reset, so that no transfer is seen as accepted.
  assign ack        = grant & {NUM_CH{reset_n}};
  assign grant_addr = addr_ch[grant_ch];

`ifdef IMAGE_ROM_BOUNDS_CHECK_EN
  // Zero-extend the address before the compare, so that no address bits are lost.
  assign grant_oob = (32'(grant_addr) >= 32'(DEPTH));
  // Out-of-range addresses are redirected to word 0. Their data is replaced later.
  assign rd_addr   = grant_oob ? '0 : grant_addr;
`else
  assign grant_oob = 1'b0;
  assign rd_addr   = grant_addr;
`endif

  // The ROM read register has no reset, so that it maps onto the block RAM
  // output register.
  logic [DATA_W-1:0] q_reg;

  always_ff @(posedge clock) begin
    q_reg <= mem[rd_addr];
  end

  logic              s1_valid_reg;
  logic [PTR_W-1:0]  s1_ch_reg;
  logic              s1_oob_reg;
  logic [NUM_CH-1:0] rvalid_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              oob_err_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_ch_reg    <= '0;
      s1_oob_reg   <= 1'b0;
      rvalid_reg   <= '0;
      rdata_reg    <= '0;
      oob_err_reg  <= 1'b0;
    end else begin
      ptr_reg      <= ptr_next;
      // Stage 1: tags travel alongside the ROM read.
      s1_valid_reg <= grant_any;
      s1_ch_reg    <= grant_ch;
      s1_oob_reg   <= grant_oob;
      // Stage 2: register the ROM word with its tags. rdata holds while idle.
      rvalid_reg   <= s1_valid_reg ? (NUM_CH'(1) << s1_ch_reg) : '0;
      oob_err_reg  <= s1_valid_reg & s1_oob_reg;
      if (s1_valid_reg) begin
        rdata_reg <= s1_oob_reg ? OOB_VALUE : q_reg;
      end
    end
  end

  assign rvalid  = rvalid_reg;
  assign rdata   = rdata_reg;
  assign oob_err = oob_err_reg;

endmodule

// File: tb/tb_image_rom_mux.sv
// tb_image_rom_mux
// Bench for image_rom_mux. The ROM is preloaded with a known pattern. The bench
// runs directed sequences and then random request traffic. Its reference model
// is a rotating-priority search plus a queue of expected responses, each tagged
// with the cycle in which it is due.
module tb_image_rom_mux;

  localparam int         DATA_W    = 4;
  localparam int         DEPTH     = 1000;
  localparam int         ADDR_W    = 10;
  localparam int         NUM_CH    = 2;
  localparam logic [3:0] OOB_VALUE = 4'hF;
  localparam int         ADDR_MAX  = (1 << ADDR_W) - 1;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b1;
  logic [NUM_CH-1:0]        req = '0;
  logic [NUM_CH*ADDR_W-1:0] addr = '0;
  logic [NUM_CH-1:0]        ack;
  logic [DATA_W-1:0]        rdata;
  logic [NUM_CH-1:0]        rvalid;
  logic                     oob_err;

  always #5 clock = ~clock;

  image_rom_mux #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
    .OOB_VALUE(OOB_VALUE), .INIT_FILE("image.mif")
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .addr(addr),
    .ack(ack), .rdata(rdata), .rvalid(rvalid), .oob_err(oob_err)
  );

  typedef struct {
    int due;
    int ch;
    int data;
    bit oob;
    bit known;
  } resp_t;

  resp_t exp_q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    model_ptr = 0;
  int    last_rdata = 0;
  bit    last_known = 1'b0;

  function automatic int pat(int a);
    return (a * 7 + a / 16 + 3) % 16;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(logic [NUM_CH-1:0] r, int a0, int a1);
    req  = r;
    addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  // One clock cycle. The bench checks outputs and the grant mid-cycle, updates
  // the model, and then moves to just after the next rising edge.
  task automatic tick();
    resp_t e;
    int    g;
    int    c;
    int    a;
    bit    is_oob;
    @(negedge clock);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("rvalid", 32'(rvalid), 32'(1 << e.ch));
      check("oob_err", 32'(oob_err), 32'(e.oob));
      if (e.known) begin
        check("rdata", 32'(rdata), 32'(e.data));
        last_rdata = e.data;
        last_known = 1'b1;
      end else begin
        last_known = 1'b0;
      end
      $display("[TB] cyc %0d ch %0d rdata %0h oob_err %0b", cyc, e.ch, rdata, oob_err);
    end else begin
      check("rvalid_idle", 32'(rvalid), 32'd0);
      check("oob_err_idle", 32'(oob_err), 32'd0);
      if (last_known) check("rdata_hold", 32'(rdata), 32'(last_rdata));
    end
    g = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (model_ptr + k) % NUM_CH;
      if (g < 0 && req[c]) g = c;
    end
    check("ack", 32'(ack), (g >= 0) ? 32'(1 << g) : 32'd0);
    if (g >= 0) begin
      a      = int'(addr[g*ADDR_W +: ADDR_W]);
      is_oob = (a >= DEPTH);
      e.due  = cyc + 2;
      e.ch   = g;
`ifdef IMAGE_ROM_BOUNDS_CHECK_EN
      e.data  = is_oob ? int'(OOB_VALUE) : pat(a);
      e.oob   = is_oob;
      e.known = 1'b1;
`else
      e.data  = pat(a);
      e.oob   = 1'b0;
      e.known = !is_oob;
`endif
      exp_q.push_back(e);
      model_ptr = (g + 1) % NUM_CH;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    exp_q.delete();
    model_ptr  = 0;
    last_rdata = 0;
    last_known = 1'b1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_oob_err", 32'(oob_err), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle(int n);
    drive('0, 0, 0);
    repeat (n) tick();
  endtask

  int ra0, ra1;

  initial begin
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = DATA_W'(pat(i));

    // Single read
    drive(2'b11, 0, 0);
    do_reset();
    drive(2'b01, 5, 0);
    tick();
    idle(3);

    // Contention starts from channel 0 after reset
    do_reset();
    drive(2'b11, 10, 20);
    repeat (6) tick();
    idle(3);

    // Back-to-back reads on channel 1
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 0, i);
      tick();
    end
    idle(3);

    // Bounds: first and last legal word, DEPTH, and the top of the address range
    drive(2'b01, DEPTH - 1, 0);        tick();
    drive(2'b01, DEPTH, 0);            tick();
    drive(2'b10, 0, ADDR_MAX);         tick();
    drive(2'b01, 0, 0);                tick();
    idle(3);

    // Dropped request: channel 1 wins, channel 0 withdraws, pointer moved past 1
    do_reset();
    drive(2'b01, 1, 0);  tick();
    drive(2'b11, 2, 3);  tick();
    drive(2'b00, 2, 3);  tick();
    drive(2'b11, 4, 5);  tick();
    idle(3);

    // Reset mid-flight: grant address 7, then assert reset in the next cycle
    drive(2'b01, 7, 0);
    tick();
    drive('0, 0, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    check("midrst_oob_err", 32'(oob_err), 32'd0);
    do_reset();
    idle(4);

    // Random traffic, about 10% of it out of range
    for (int n = 0; n < 400; n++) begin
      ra0 = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, ADDR_MAX) : $urandom_range(0, DEPTH - 1);
      ra1 = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, ADDR_MAX) : $urandom_range(0, DEPTH - 1);
      drive(NUM_CH'($urandom_range(0, 3)), ra0, ra1);
      tick();
    end
    idle(4);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
